// File: rtl/dmem_access_unit.sv
// Data-memory access controller: runs one MEM-stage request per bus transaction and stalls until done.
// Optional misaligned-access trap is compiled in with `define DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic        req_re,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_type,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [3:0]  bus_strb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_BUS_ERR  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 req_active;
  logic                 misalign;
  logic                 timeout_hit;

  assign req_active  = req_re | req_we;
  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);
  assign stall       = req_active && (state != S_DONE);
  assign bus_valid   = (state == S_WAIT);

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [2:0] MEM_HALF   = 3'b001;
  localparam logic [2:0] MEM_WORD   = 3'b010;
  localparam logic [2:0] MEM_HALF_U = 3'b101;

  always_comb begin
    misalign = 1'b0;
    case (req_type)
      MEM_WORD:             misalign = (req_addr[1:0] != 2'b00);
      MEM_HALF, MEM_HALF_U: misalign = req_addr[0];
      default:              misalign = 1'b0;
    endcase
  end
`else
  logic unused_req;
  assign misalign   = 1'b0;
  assign unused_req = ^{req_type, req_addr[1:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_active) state_nxt = misalign ? S_DONE : S_WAIT;
      S_WAIT:  if (bus_ready || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus registers are only loaded in IDLE, so they stay stable for the whole WAIT phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_we      <= 1'b0;
      bus_strb    <= '0;
      wait_cnt    <= '0;
    end else begin
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      case (state)
        S_IDLE: begin
          if (req_active) begin
            if (misalign) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
            end else begin
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_wdata <= req_wdata;
              bus_we    <= req_we;
              bus_strb  <= req_we ? req_strb : 4'b0000;
              wait_cnt  <= '0;
            end
          end
        end
        S_WAIT: begin
          if (bus_ready) begin
            if (!bus_we) rdata <= bus_rdata;
            if (bus_err) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_BUS_ERR;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) begin
              rdata       <= '0;
              fault       <= 1'b1;
              fault_cause <= CAUSE_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit (timeout shortened to 4 cycles).
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr, req_wdata;
  logic        req_we, req_re;
  logic [3:0]  req_strb;
  logic [2:0]  req_type;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        bus_valid;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_we;
  logic [3:0]  bus_strb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_re(req_re),
    .req_strb(req_strb), .req_type(req_type),
    .stall(stall), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_strb(bus_strb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request starting in IDLE and acts as the slave: ready after 'waits' valid cycles
  // (negative = never). Stops in the first cycle with stall low and returns what was seen there.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re,
                         input logic [3:0] st, input logic [2:0] ty, input int waits,
                         input logic err, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                         output int n_stall, output int n_valid,
                         output logic f, output logic [1:0] fc, output logic [31:0] rdo);
    bit done = 0;
    req_addr = a; req_wdata = wd; req_we = we; req_re = re; req_strb = st; req_type = ty;
    bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = rd;
    n_stall = 0; n_valid = 0; f = 1'b0; fc = 2'b00; rdo = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) begin
        f = fault; fc = fault_cause; rdo = rdata;
        check("valid_in_done", bus_valid, 1'b0);
        done = 1;
        break;
      end
      n_stall++;
      if (bus_valid) begin
        check("bus_addr", bus_addr, exp_addr);
        check("bus_strb", bus_strb, exp_strb);
        check("bus_we", bus_we, we);
        bus_ready = (n_valid == waits);
        bus_err   = err && (n_valid == waits);
        n_valid++;
      end else begin
        bus_ready = 1'b0;
        bus_err   = 1'b0;
      end
      @(posedge clk);
    end
    if (!done) check("txn_bound", 32'd0, 32'd1);
    req_re = 1'b0; req_we = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
    step();
  endtask

  int          ns, nv;
  logic        f;
  logic [1:0]  fc;
  logic [31:0] rdo;

  initial begin
    #100000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_addr = '0; req_wdata = '0; req_we = 1'b0; req_re = 1'b0; req_strb = '0; req_type = 3'b010;
    bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    #23;
    check("rst_stall", stall, 1'b0);
    check("rst_valid", bus_valid, 1'b0);
    check("rst_fault", {fault, fault_cause}, 3'b000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_we_strb", {bus_we, bus_strb}, 5'b0);
    step();
    rst = 1'b0;
    step();

    // Load, zero-wait slave
    run_txn(32'h0000_1004, 32'h0, 1'b0, 1'b1, 4'b1111, 3'b010, 0, 1'b0, 32'hDEADBEEF,
            32'h0000_1004, 4'b0000, ns, nv, f, fc, rdo);
    check("load_stall", ns, 2);
    check("load_valid", nv, 1);
    check("load_rdata", rdo, 32'hDEADBEEF);
    check("load_fault", {f, fc}, 3'b000);

    // Store with 3 wait states; ready lands in the last timeout cycle and must win
    run_txn(32'h0000_2002, 32'h1234_0000, 1'b1, 1'b0, 4'b1100, 3'b001, 3, 1'b0, 32'hFFFF_FFFF,
            32'h0000_2000, 4'b1100, ns, nv, f, fc, rdo);
    check("store_stall", ns, 5);
    check("store_valid", nv, 4);
    check("store_wdata", bus_wdata, 32'h1234_0000);
    check("store_keeps_rdata", rdo, 32'hDEADBEEF);
    check("store_fault", {f, fc}, 3'b000);

    // Bus error on a load
    run_txn(32'h0000_3008, 32'h0, 1'b0, 1'b1, 4'b0000, 3'b010, 0, 1'b1, 32'h0000_0055,
            32'h0000_3008, 4'b0000, ns, nv, f, fc, rdo);
    check("err_fault", {f, fc}, 3'b101);
    check("err_stall", ns, 2);
    check("err_pulse_end", {fault, fault_cause}, 3'b000);
    check("err_idle_valid", bus_valid, 1'b0);

    // Timeout: slave never ready
    run_txn(32'h0000_4000, 32'h0, 1'b0, 1'b1, 4'b0000, 3'b010, -1, 1'b0, 32'hAAAA_AAAA,
            32'h0000_4000, 4'b0000, ns, nv, f, fc, rdo);
    check("to_valid", nv, 4);
    check("to_stall", ns, 5);
    check("to_fault", {f, fc}, 3'b111);
    check("to_rdata", rdo, 32'h0);

    // Reset during the second WAIT cycle
    req_addr = 32'h0000_5000; req_re = 1'b1; req_type = 3'b010; bus_ready = 1'b0;
    step();
    step();
    check("mid_valid_before", bus_valid, 1'b1);
    rst = 1'b1; req_re = 1'b0;
    #1;
    check("mid_rst_valid", bus_valid, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    step();
    check("mid_rst_fault", fault, 1'b0);
    rst = 1'b0;
    step();
    run_txn(32'h0000_600C, 32'h0, 1'b0, 1'b1, 4'b0000, 3'b010, 1, 1'b0, 32'hCAFE_F00D,
            32'h0000_600C, 4'b0000, ns, nv, f, fc, rdo);
    check("post_rst_stall", ns, 3);
    check("post_rst_rdata", rdo, 32'hCAFE_F00D);
    check("post_rst_fault", {f, fc}, 3'b000);

    // Misaligned WORD load
    run_txn(32'h0000_1001, 32'h0, 1'b0, 1'b1, 4'b0000, 3'b010, 0, 1'b0, 32'h1111_2222,
            32'h0000_1000, 4'b0000, ns, nv, f, fc, rdo);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_valid", nv, 0);
    check("mis_stall", ns, 1);
    check("mis_fault", {f, fc}, 3'b110);
    check("mis_rdata", rdo, 32'hCAFE_F00D);
`else
    check("mis_valid", nv, 1);
    check("mis_stall", ns, 2);
    check("mis_fault", {f, fc}, 3'b000);
    check("mis_rdata", rdo, 32'h1111_2222);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Data-memory access controller directly downstream of the MEM stage.
- Consumes the MEM stage's flat memory request (address, write data, write enable, byte strobes, access type) and runs it as a registered valid/ready transaction on the data bus.
- Holds the pipeline via `stall` until the response returns, then presents read data to the MEM stage's load-extension logic.
- Reports bus errors and timeouts as faults.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without `bus_ready` before abort; 0 disables the timeout.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_addr  in  32  byte address from the MEM stage.
- req_wdata  in  32  store data, already lane-positioned.
- req_we  in  1  store request.
- req_re  in  1  load request.
- req_strb  in  4  byte write strobes.
- req_type  in  3  access type (MEM_BYTE/HALF/WORD/BYTE_U/HALF_U from the shared defines).
- stall  out  1  freeze the pipeline upstream of and including MEM.
- rdata  out  32  raw 32-bit read word; valid only in DONE.
- fault  out  1  one-cycle fault pulse, asserted in DONE.
- fault_cause  out  2  00 none, 01 bus error, 10 misaligned, 11 timeout.
- bus_valid  out  1  transaction request.
- bus_addr  out  32  word-aligned address, req_addr[31:2]. Low two bits are 0.
- bus_wdata  out  32  registered store data.
- bus_we  out  1  registered write enable.
- bus_strb  out  4  registered strobes; 0000 on reads.
- bus_ready  in  1  slave accepts and completes the transaction.
- bus_rdata  in  32  read data, valid with `bus_ready`.
- bus_err  in  1  slave error, valid with `bus_ready`.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - `stall`, `bus_valid`, `bus_we`, `fault` = 0.
  - `bus_strb`, `fault_cause` = 0.
  - `rdata`, `bus_addr`, `bus_wdata` = 0.
  - Timeout counter = 0.
  - Reset mid-transaction drops `bus_valid` at once; no completion is reported.
- req_active = `req_re` | `req_we`. If both are set, the request is treated as a write.
- `stall` is combinational: req_active & (state != DONE).
- IDLE:
  - req_active → latch addr/wdata/we/strb into bus registers, clear the counter, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - `bus_valid` = 1. All bus_* outputs are stable until `bus_ready`.
  - `bus_ready` = 1 → `rdata` <= `bus_rdata` (reads only; writes leave `rdata` unchanged); go to DONE.
    - If `bus_err` = 1 at the same time, `fault` = 1 and `fault_cause` = 01 in DONE.
  - `bus_ready` = 0 → counter++.
    - If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: go to DONE, `rdata` = 0, `fault_cause` = 11. `bus_valid` drops; the slave must tolerate abandonment.
  - `bus_ready` in the final timeout cycle takes priority over the timeout.
- DONE:
  - `stall` = 0 for exactly one cycle; the pipeline advances.
  - `fault`/`fault_cause` valid this cycle only.
  - Go to IDLE unconditionally. Any new request is taken in IDLE next cycle.
- Latency:
  - Request at cycle 0 → `bus_valid` at cycle 1.
  - Zero-wait slave: `bus_ready` at cycle 1, DONE at cycle 2.
  - `stall` is high for cycles 0-1, low at cycle 2.
  - Each wait state adds 1 cycle.
- No request is ever issued twice: a held request is not re-latched while in WAIT or DONE.
- `bus_valid` never asserts in IDLE or DONE.

Optional Feature:
- DMEM_MISALIGN_TRAP_EN defined:
  - In IDLE, these requests skip the bus: WORD with addr[1:0] != 00, and HALF/HALF_U with addr[0] = 1.
  - Path is IDLE → DONE directly, with `fault` = 1, `fault_cause` = 10, `rdata` unchanged, `bus_valid` never asserted.
  - Stall length is 1 cycle.
- Undefined:
  - `req_type` is ignored and all requests go to the bus.
  - `fault_cause` = 10 is never produced.

Test Plan:
- Load: addr 0x0000_1004, zero-wait slave, `bus_rdata` = 0xDEADBEEF.
  - Required: `bus_valid` at cycle 1, `bus_addr` = 0x1004, `bus_strb` = 0000.
  - `stall` high for 2 cycles; `rdata` = 0xDEADBEEF in DONE; `fault` = 0.
- Store: addr 0x2002, strb 1100, wdata 0x12340000, slave ready after 3 wait cycles.
  - Required: `bus_valid` held 4 cycles with stable addr 0x2000, strb 1100, we 1.
  - `stall` high for 5 cycles.
- Bus error: `bus_ready` = 1, `bus_err` = 1 on a load.
  - Required: `fault` pulse of 1 cycle with `fault_cause` = 01; FSM back to IDLE.
- Timeout: TIMEOUT_CYCLES = 4, `bus_ready` never asserted.
  - Required: `bus_valid` high for 4 cycles, then DONE with `fault_cause` = 11, `rdata` = 0.
- Reset mid-op: `rst` asserted in WAIT cycle 2.
  - Required: `bus_valid` = 0 and `stall` = 0 immediately after reset.
  - A new load after reset completes normally.
- With DMEM_MISALIGN_TRAP_EN: WORD load at 0x1001.
  - Required: no `bus_valid`, `stall` high for 1 cycle, `fault_cause` = 10.
  - Without the macro: the same request issues on the bus with `bus_addr` = 0x1000.
